// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the jump encoder: opcodes, error-bit
// positions and the output-stage FSM encoding.
package mips_isa_pkg;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;

  // Bit positions inside out_err
  localparam int unsigned ERR_REGION = 0;
  localparam int unsigned ERR_ALIGN  = 1;
  localparam int unsigned ERR_W      = 2;

  // EMPTY: nothing held; FULL: encoded word presented on the outputs
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } enc_state_e;

endpackage

// File: rtl/jump_encoder_if.sv
// Request/response bundle of the jump encoder.
// master: requester and consumer side; slave: the encoder itself.
interface jump_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] target;
  logic        link;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [1:0]  out_err;

  modport master (
    output in_valid, pc, target, link, out_ready,
    input  in_ready, out_valid, instr, out_err
  );

  modport slave (
    input  in_valid, pc, target, link, out_ready,
    output in_ready, out_valid, instr, out_err
  );

endinterface

// File: rtl/jump_field_pack.sv
// Combinational J/JAL field check and pack. An out-of-region or misaligned
// target yields a NOP word plus the matching error bits.
module jump_field_pack
  import mips_isa_pkg::*;
#(
  parameter logic [5:0] OPC_J   = mips_isa_pkg::OPC_J,
  parameter logic [5:0] OPC_JAL = mips_isa_pkg::OPC_JAL
) (
  input  logic [31:0]      pc,
  input  logic [31:0]      target,
  input  logic             link,
  output logic [31:0]      instr,
  output logic [ERR_W-1:0] err
);

  // Only the region nibble of pc matters for a pseudo-direct jump
  logic unused_pc;
  assign unused_pc = ^pc[27:0];

  // Classify the target and build the instruction word
  always_comb begin
    err             = '0;
    err[ERR_REGION] = (target[31:28] != pc[31:28]);
    err[ERR_ALIGN]  = (target[1:0] != 2'b00);
    if (|err) begin
      instr = 32'h0000_0000;
    end else begin
      instr = {(link ? OPC_JAL : OPC_J), target[27:2]};
    end
  end

endmodule

// File: rtl/jump_encoder.sv
// Jump encoder: accepts {pc, target, link} requests and emits J/JAL words
// through a one-deep output register with valid/ready handshakes.
// Optional statistics counters (enc_cnt, err_cnt) are built only when
// JUMP_ENC_STATS_EN is defined.
module jump_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter logic [5:0]  OPC_J   = mips_isa_pkg::OPC_J,
  parameter logic [5:0]  OPC_JAL = mips_isa_pkg::OPC_JAL
) (
  input  logic             clk,
  input  logic             rst_n,
  jump_encoder_if.slave    bus,
  input  logic             clr,
  output logic             err_sticky
`ifdef JUMP_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  enc_state_e       state_q, state_d;
  logic [31:0]      instr_q;
  logic [ERR_W-1:0] err_q;
  logic             sticky_q;

  logic [31:0]      pack_instr;
  logic [ERR_W-1:0] pack_err;
  logic             accept;
  logic             pack_bad;

  jump_field_pack #(
    .OPC_J   (OPC_J),
    .OPC_JAL (OPC_JAL)
  ) u_pack (
    .pc     (bus.pc),
    .target (bus.target),
    .link   (bus.link),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  // Handshake decode; in_ready never looks at in_valid
  always_comb begin
    bus.in_ready  = (state_q == StEmpty) | bus.out_ready;
    bus.out_valid = (state_q == StFull);
    accept        = bus.in_valid & bus.in_ready;
    pack_bad      = |pack_err;
  end

  // Next-state: a new word keeps us FULL, a drain without refill empties
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull: begin
        if (accept)             state_d = StFull;
        else if (bus.out_ready) state_d = StEmpty;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Output word register, loaded only on accept so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      err_q   <= '0;
    end else if (accept) begin
      instr_q <= pack_instr;
      err_q   <= pack_err;
    end
  end

  // Sticky error: a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   sticky_q <= 1'b0;
    else if (accept && pack_bad)  sticky_q <= 1'b1;
    else if (clr)                 sticky_q <= 1'b0;
  end

  assign bus.instr   = instr_q;
  assign bus.out_err = err_q;
  assign err_sticky  = sticky_q;

`ifdef JUMP_ENC_STATS_EN
  logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;

  // Saturating counters; clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (clr) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (accept) begin
      if (enc_cnt_q != '1)             enc_cnt_q <= enc_cnt_q + CNT_W'(1);
      if (pack_bad && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign enc_cnt = enc_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_jump_encoder.sv
// Directed-vector and scoreboard bench for jump_encoder.
module tb_jump_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic err_sticky;
`ifdef JUMP_ENC_STATS_EN
  logic [15:0] enc_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  jump_encoder_if bus();

  jump_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr        (clr),
    .err_sticky (err_sticky)
`ifdef JUMP_ENC_STATS_EN
    ,
    .enc_cnt    (enc_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        link;
    logic [31:0] exp_instr;
    logic [1:0]  exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] instr;
    logic [1:0]  err;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;
  logic        m_sticky = 1'b0;
  logic [15:0] m_enc = '0;
  logic [15:0] m_err = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] target,
                                 input logic link);
    exp_t e;
    e.pc     = pc;
    e.target = target;
    e.err[0] = (pc[31:28] != target[31:28]);
    e.err[1] = (target[1:0] != 2'b00);
    e.instr  = (e.err != 2'b00) ? 32'h0 : {(link ? 6'b000011 : 6'b000010), target[27:2]};
    return e;
  endfunction

  // Observe what the coming rising edge will do (inputs are stable here)
  task automatic mon();
    exp_t e;
    logic acc, bad;
    if (bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("sb_instr", bus.instr, e.instr);
        check("sb_err", {30'd0, bus.out_err}, {30'd0, e.err});
        if (e.err == 2'b00)
          check("round_trip", {e.pc[31:28], bus.instr[25:0], 2'b00}, e.target);
      end
    end
    acc = bus.in_valid && bus.in_ready;
    bad = 1'b0;
    if (acc) begin
      e = model(bus.pc, bus.target, bus.link);
      sbq.push_back(e);
      n_acc++;
      bad = (e.err != 2'b00);
    end
    if (acc && bad) m_sticky = 1'b1;
    else if (clr)   m_sticky = 1'b0;
    if (clr) begin
      m_enc = '0;
      m_err = '0;
    end else if (acc) begin
      if (m_enc != 16'hFFFF)        m_enc++;
      if (bad && m_err != 16'hFFFF) m_err++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef JUMP_ENC_STATS_EN
    check({tag, "_enc_cnt"}, {16'd0, enc_cnt}, {16'd0, m_enc});
    check({tag, "_err_cnt"}, {16'd0, err_cnt}, {16'd0, m_err});
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    logic [31:0] r;
    int          cyc;

    vecs[0] = '{32'h0040_0000, 32'h0040_0010, 1'b0, 32'h0810_0004, 2'b00};
    vecs[1] = '{32'h0040_0000, 32'h0040_0010, 1'b1, 32'h0C10_0004, 2'b00};
    vecs[2] = '{32'h1000_0000, 32'h2000_0000, 1'b0, 32'h0000_0000, 2'b01};
    vecs[3] = '{32'h0040_0000, 32'h0040_0012, 1'b0, 32'h0000_0000, 2'b10};
    vecs[4] = '{32'h1000_0000, 32'h2000_0003, 1'b1, 32'h0000_0000, 2'b11};
    vecs[5] = '{32'hF000_0000, 32'hFFFF_FFFC, 1'b1, 32'h0FFF_FFFF, 2'b00};
    vecs[6] = '{32'h3000_0004, 32'h3000_0000, 1'b0, 32'h0800_0000, 2'b00};
    vecs[7] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0000, 2'b10};

    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pc        = '0;
    bus.target    = '0;
    bus.link      = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_out_err", {30'd0, bus.out_err}, 32'd0);
    check("rst_sticky", {31'd0, err_sticky}, 32'd0);
    check_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back-to-back with the consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.pc       = vecs[i].pc;
      bus.target   = vecs[i].target;
      bus.link     = vecs[i].link;
      tick();
      check($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("vec%0d_instr", i), bus.instr, vecs[i].exp_instr);
      check($sformatf("vec%0d_out_err", i), {30'd0, bus.out_err}, {30'd0, vecs[i].exp_err});
    end
    bus.in_valid = 1'b0;
    tick();
    check("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("sticky_after_errors", {31'd0, err_sticky}, 32'd1);
    check_stats("vecs");

    // Clear without traffic drops sticky and counters
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sticky_after_clr", {31'd0, err_sticky}, 32'd0);
    check_stats("clr");

    // Clear coinciding with an errored accept leaves sticky set
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.pc       = 32'h1000_0000;
    bus.target   = 32'h2000_0000;
    tick();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    check("sticky_clr_vs_err", {31'd0, err_sticky}, 32'd1);
    check_stats("clr_err");
    tick();

    // Backpressure: hold A for 5 cycles while B waits, then release
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.pc        = 32'h0040_0000;
    bus.target    = 32'h0040_0100;
    bus.link      = 1'b0;
    tick();
    bus.target    = 32'h0040_0200;
    bus.link      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_instr_held", bus.instr, 32'h0810_0040);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_second_instr", bus.instr, 32'h0C10_0080);
    tick();
    check("bp_drained", {31'd0, bus.out_valid}, 32'd0);
    check("bp_sb_empty", sbq.size(), 32'd0);

    // Reset while FULL: outputs drop without waiting for a clock
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.target    = 32'h0040_0300;
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_full", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_instr", bus.instr, 32'd0);
    check("async_rst_sticky", {31'd0, err_sticky}, 32'd0);
    sbq.delete();
    m_sticky = 1'b0;
    m_enc    = '0;
    m_err    = '0;
    check_stats("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Random traffic with scoreboard and round-trip check
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 8);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.pc        = $urandom;
      r             = $urandom;
      if ($urandom_range(0, 9) < 7) bus.target = {bus.pc[31:28], r[27:2], 2'b00};
      else                          bus.target = r;
      bus.link      = r[0];
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("random_all_accepted", {31'd0, (n_acc >= 10000)}, 32'd1);
    check("random_sb_empty", sbq.size(), 32'd0);
    check("random_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    check_stats("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_encoder.md
JUMP_ENCODER -- requirements
Module: jump_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-002 SHALL have parameter OPC_J, default 6'b000010, J-type opcode.
REQ-003 SHALL have parameter OPC_JAL, default 6'b000011, JAL opcode.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-008 SHALL have port pc  input  32  address of the jump instruction.
REQ-009 SHALL have port target  input  32  desired jump destination.
REQ-010 SHALL have port link  input  1  1 = encode JAL, 0 = encode J.
REQ-011 SHALL have port out_valid  output  1  encoded word available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the word.
REQ-013 SHALL have port instr  output  32  encoded instruction word.
REQ-014 SHALL have port out_err  output  2  bit0 = region error, bit1 = alignment error.
REQ-015 SHALL have port clr  input  1  synchronous clear of sticky error and counters.
REQ-016 SHALL have port err_sticky  output  1  any error since reset/clr.
REQ-017 SHALL have ports enc_cnt and err_cnt  output  CNT_W each  statistics (present only with JUMP_ENC_STATS_EN).

Function
REQ-018 SHALL use a two-state FSM: EMPTY (no held word) and FULL (word held on outputs).
REQ-019 SHALL drive in_ready = (state==EMPTY) | out_ready; combinational, no dependence on in_valid.
REQ-020 SHALL, on accept (in_valid & in_ready), register the result and enter/stay FULL; latency 1 cycle, throughput 1 per cycle.
REQ-021 SHALL, in FULL with out_ready & !accept, return to EMPTY.
REQ-022 SHALL hold instr, out_err stable while out_valid & !out_ready.
REQ-023 SHALL assert out_valid exactly when state==FULL.
REQ-024 SHALL flag region error when target[31:28] != pc[31:28].
REQ-025 SHALL flag alignment error when target[1:0] != 2'b00.
REQ-026 SHALL, with no error, produce instr = {link?OPC_JAL:OPC_J, target[27:2]}.
REQ-027 SHALL, with any error, produce instr = 32'h0000_0000 (NOP) and still deliver out_valid with out_err set.
REQ-028 SHALL guarantee round-trip: {pc[31:28], instr[25:0], 2'b00} == target for every error-free output.
REQ-029 SHALL set err_sticky on accept of an errored request; clr clears it; simultaneous clr and errored accept leaves it set.
REQ-030 SHALL ignore in_valid pulses when in_ready is low (no implicit queuing).

Reset
REQ-031 SHALL on rst_n low, immediately: state EMPTY, out_valid 0, instr 0, out_err 0, err_sticky 0, counters 0.
REQ-032 SHALL discard any held word when reset asserts mid-transfer; first post-reset cycle in_ready=1.

Configuration
REQ-033 SHALL, with JUMP_ENC_STATS_EN defined, count accepted requests in enc_cnt and errored ones in err_cnt, both saturating at all-ones, cleared by clr (clr wins over increment).
REQ-034 SHALL, without JUMP_ENC_STATS_EN, omit enc_cnt/err_cnt ports and logic entirely; all other behaviour identical.

Structure
REQ-035 SHALL place OPC_J, OPC_JAL, error-bit indices and FSM state encoding in shared package mips_isa_pkg.
REQ-036 SHALL isolate the combinational field check/pack in one sub-module jump_field_pack; FSM, registers, counters stay in jump_encoder.

Verification
REQ-037 SHALL cover: pc=0x0040_0000, target=0x0040_0010, link=0 -> next cycle instr=0x0810_0004, out_err=0.
REQ-038 SHALL cover: same with link=1 -> instr=0x0C10_0004, out_err=0.
REQ-039 SHALL cover: pc=0x1000_0000, target=0x2000_0000 -> instr=0, out_err=2'b01, err_sticky=1.
REQ-040 SHALL cover: target=0x0040_0012 -> instr=0, out_err=2'b10; then clr -> err_sticky=0, err_cnt=0.
REQ-041 SHALL cover: out_ready low 5 cycles with back-to-back requests -> in_ready low, instr held, no loss or duplication after release.
REQ-042 SHALL cover: rst_n dropped while FULL -> out_valid 0 asynchronously, counters 0, random round-trip check (REQ-028) over 10k requests.
